// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory bus between IF fetches and MEM load/stores.
// MEM has strict priority; bus outputs are registered and held until ack or watchdog abort.
module mem_port_arbiter #(
  parameter int BUS_W       = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifReqIn,
  input  logic [BUS_W-1:0] ifAddrIn,
  input  logic             ifFlushIn,
  output logic [BUS_W-1:0] ifDataOut,
  output logic             ifValidOut,
  input  logic             memReqIn,
  input  logic             memWeIn,
  input  logic [BUS_W-1:0] memAddrIn,
  input  logic [BUS_W-1:0] memWDataIn,
  input  logic [3:0]       memBeIn,
  output logic [BUS_W-1:0] memRDataOut,
  output logic             memValidOut,
  output logic             stallIFOut,
  output logic             stallMEMOut,
  output logic             busReqOut,
  output logic             busWeOut,
  output logic [BUS_W-1:0] busAddrOut,
  output logic [BUS_W-1:0] busWDataOut,
  output logic [3:0]       busBeOut,
  input  logic [BUS_W-1:0] busRDataIn,
  input  logic             busAckIn,
  output logic             timeoutOut
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC, IF_DROP} state_t;

  typedef struct packed {
    logic             we;
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdata;
    logic [3:0]       be;
  } bus_req_t;

  state_t           state;
  bus_req_t         bus_q;
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_expire;
  logic             mem_grant;
  logic             if_grant;

  assign busWeOut    = bus_q.we;
  assign busAddrOut  = bus_q.addr;
  assign busWDataOut = bus_q.wdata;
  assign busBeOut    = bus_q.be;

  // A requester still holding req during its valid pulse must not be re-granted.
  assign mem_grant = memReqIn & ~memValidOut;
  assign if_grant  = ifReqIn & ~ifFlushIn & ~ifValidOut;
  assign wd_expire = (TIMEOUT_CYC != 0) && (wd_cnt == WD_LAST);

  assign stallIFOut  = ~rst & ifReqIn & ~ifValidOut & ~ifFlushIn;
  assign stallMEMOut = ~rst & memReqIn & ~memValidOut;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus_q       <= '0;
      busReqOut   <= 1'b0;
      ifDataOut   <= '0;
      ifValidOut  <= 1'b0;
      memRDataOut <= '0;
      memValidOut <= 1'b0;
      timeoutOut  <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      ifValidOut  <= 1'b0;
      memValidOut <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (mem_grant) begin
            state       <= MEM_ACC;
            busReqOut   <= 1'b1;
            bus_q.we    <= memWeIn;
            bus_q.addr  <= memAddrIn;
            bus_q.wdata <= memWDataIn;
            bus_q.be    <= memBeIn;
          end else if (if_grant) begin
            state      <= IF_ACC;
            busReqOut  <= 1'b1;
            bus_q.we   <= 1'b0;
            bus_q.addr <= ifAddrIn;
            bus_q.be   <= 4'hF;
          end
        end
        default: begin
          if (busAckIn) begin
            state     <= IDLE;
            busReqOut <= 1'b0;
            // A flush landing on the ack edge still kills the fetch.
            if (state == IF_ACC && !ifFlushIn) begin
              ifDataOut  <= busRDataIn;
              ifValidOut <= 1'b1;
            end
            if (state == MEM_ACC) begin
              memValidOut <= 1'b1;
              if (!bus_q.we) memRDataOut <= busRDataIn;
            end
          end else if (wd_expire) begin
            state      <= IDLE;
            busReqOut  <= 1'b0;
            timeoutOut <= 1'b1;
          end else begin
            if (TIMEOUT_CYC != 0) wd_cnt <= wd_cnt + 1'b1;
            if (state == IF_ACC && ifFlushIn) state <= IF_DROP;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, collision, store, flush, watchdog, reset.
module tb_mem_port_arbiter;
  localparam int BUS_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             ifReqIn, ifFlushIn, memReqIn, memWeIn, busAckIn;
  logic [BUS_W-1:0] ifAddrIn, memAddrIn, memWDataIn, busRDataIn;
  logic [3:0]       memBeIn;
  logic [BUS_W-1:0] ifDataOut, memRDataOut, busAddrOut, busWDataOut;
  logic             ifValidOut, memValidOut, stallIFOut, stallMEMOut;
  logic             busReqOut, busWeOut, timeoutOut;
  logic [3:0]       busBeOut;

  int tests  = 0;
  int failed = 0;

  mem_port_arbiter #(.BUS_W(BUS_W), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .ifReqIn(ifReqIn), .ifAddrIn(ifAddrIn), .ifFlushIn(ifFlushIn),
    .ifDataOut(ifDataOut), .ifValidOut(ifValidOut),
    .memReqIn(memReqIn), .memWeIn(memWeIn), .memAddrIn(memAddrIn),
    .memWDataIn(memWDataIn), .memBeIn(memBeIn),
    .memRDataOut(memRDataOut), .memValidOut(memValidOut),
    .stallIFOut(stallIFOut), .stallMEMOut(stallMEMOut),
    .busReqOut(busReqOut), .busWeOut(busWeOut), .busAddrOut(busAddrOut),
    .busWDataOut(busWDataOut), .busBeOut(busBeOut),
    .busRDataIn(busRDataIn), .busAckIn(busAckIn), .timeoutOut(timeoutOut)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; ifReqIn = 1'b0; ifFlushIn = 1'b0; memReqIn = 1'b0; memWeIn = 1'b0;
    busAckIn = 1'b0; ifAddrIn = '0; memAddrIn = '0; memWDataIn = '0; busRDataIn = '0;
    memBeIn = 4'h0;
    step(); step();
    // Reset state; stalls forced low while rst is high
    ifReqIn = 1'b1; memReqIn = 1'b1; #1;
    chk("rst_stall_if", stallIFOut, 0);
    chk("rst_stall_mem", stallMEMOut, 0);
    step();
    chk("rst_busreq", busReqOut, 0);
    chk("rst_busaddr", busAddrOut, 0);
    chk("rst_ifvalid", ifValidOut, 0);
    chk("rst_timeout", timeoutOut, 0);
    chk("rst_memrdata", memRDataOut, 0);
    ifReqIn = 1'b0; memReqIn = 1'b0; rst = 1'b0;
    step();

    // Fetch with ack at cycle 1
    ifReqIn = 1'b1; ifAddrIn = 32'h100; #1;
    chk("f_stall_c0", stallIFOut, 1);
    chk("f_busreq_c0", busReqOut, 0);
    step();
    chk("f_busreq_c1", busReqOut, 1);
    chk("f_busaddr_c1", busAddrOut, 32'h100);
    chk("f_busbe_c1", busBeOut, 4'hF);
    chk("f_buswe_c1", busWeOut, 0);
    chk("f_stall_c1", stallIFOut, 1);
    busAckIn = 1'b1; busRDataIn = 32'h00500093;
    step();
    chk("f_valid_c2", ifValidOut, 1);
    chk("f_data_c2", ifDataOut, 32'h00500093);
    chk("f_busreq_c2", busReqOut, 0);
    chk("f_stall_c2", stallIFOut, 0);
    busAckIn = 1'b0;
    step();
    chk("f_valid_c3", ifValidOut, 0);
    chk("f_no_regrant_c3", busReqOut, 0);
    ifReqIn = 1'b0;
    step();

    // Collision: MEM load first, then IF
    memReqIn = 1'b1; memWeIn = 1'b0; memAddrIn = 32'h2000; memBeIn = 4'hF;
    ifReqIn = 1'b1; ifAddrIn = 32'h104; #1;
    chk("c_stallif_c0", stallIFOut, 1);
    chk("c_stallmem_c0", stallMEMOut, 1);
    step();
    chk("c_busaddr_c1", busAddrOut, 32'h2000);
    chk("c_busreq_c1", busReqOut, 1);
    step();
    chk("c_busreq_c2", busReqOut, 1);
    busAckIn = 1'b1; busRDataIn = 32'hCAFE0001;
    step();
    chk("c_memvalid_c3", memValidOut, 1);
    chk("c_memdata_c3", memRDataOut, 32'hCAFE0001);
    chk("c_stallmem_c3", stallMEMOut, 0);
    chk("c_stallif_c3", stallIFOut, 1);
    chk("c_busreq_c3", busReqOut, 0);
    busAckIn = 1'b0; memReqIn = 1'b0;
    step();
    chk("c_busreq_c4", busReqOut, 1);
    chk("c_busaddr_c4", busAddrOut, 32'h104);
    chk("c_memvalid_c4", memValidOut, 0);
    step();
    chk("c_ifvalid_c5", ifValidOut, 0);
    busAckIn = 1'b1; busRDataIn = 32'h00A00113;
    step();
    chk("c_ifvalid_c6", ifValidOut, 1);
    chk("c_ifdata_c6", ifDataOut, 32'h00A00113);
    chk("c_memdata_c6", memRDataOut, 32'hCAFE0001);
    busAckIn = 1'b0; ifReqIn = 1'b0;
    step();

    // Store: bus fields follow MEM, read data untouched
    memReqIn = 1'b1; memWeIn = 1'b1; memAddrIn = 32'h2004; memWDataIn = 32'hDEADBEEF;
    memBeIn = 4'b0011;
    step();
    chk("s_busreq", busReqOut, 1);
    chk("s_buswe", busWeOut, 1);
    chk("s_busaddr", busAddrOut, 32'h2004);
    chk("s_buswdata", busWDataOut, 32'hDEADBEEF);
    chk("s_busbe", busBeOut, 4'b0011);
    busAckIn = 1'b1; busRDataIn = 32'h12345678;
    step();
    chk("s_memvalid", memValidOut, 1);
    chk("s_memdata_kept", memRDataOut, 32'hCAFE0001);
    memReqIn = 1'b0; memWeIn = 1'b0; busAckIn = 1'b0;
    step();

    // Flush while the fetch is in flight
    ifReqIn = 1'b1; ifAddrIn = 32'h200;
    step();
    chk("fl_busreq_c1", busReqOut, 1);
    step();
    ifFlushIn = 1'b1; #1;
    chk("fl_stall_flush", stallIFOut, 0);
    step();
    ifFlushIn = 1'b0; ifAddrIn = 32'h300;
    chk("fl_busreq_c3", busReqOut, 1);
    chk("fl_busaddr_c3", busAddrOut, 32'h200);
    busAckIn = 1'b1; busRDataIn = 32'h00000BAD;
    step();
    chk("fl_ifvalid_c4", ifValidOut, 0);
    chk("fl_busreq_c4", busReqOut, 0);
    chk("fl_stall_c4", stallIFOut, 1);
    busAckIn = 1'b0;
    step();
    chk("fl_regrant_busreq", busReqOut, 1);
    chk("fl_regrant_addr", busAddrOut, 32'h300);
    busAckIn = 1'b1; busRDataIn = 32'h00000013;
    step();
    chk("fl_regrant_valid", ifValidOut, 1);
    chk("fl_regrant_data", ifDataOut, 32'h00000013);
    busAckIn = 1'b0; ifReqIn = 1'b0;
    step();

    // Flush coinciding with the ack edge
    ifReqIn = 1'b1; ifAddrIn = 32'h400;
    step();
    ifFlushIn = 1'b1; ifReqIn = 1'b0; busAckIn = 1'b1; busRDataIn = 32'h77;
    step();
    chk("fa_ifvalid", ifValidOut, 0);
    chk("fa_busreq", busReqOut, 0);
    ifFlushIn = 1'b0; busAckIn = 1'b0;
    step();

    // Watchdog: no ack for 4 waiting cycles
    memReqIn = 1'b1; memWeIn = 1'b0; memAddrIn = 32'h3000; memBeIn = 4'hF;
    step();
    chk("wd_busreq_c1", busReqOut, 1);
    step(); step(); step();
    chk("wd_busreq_c4", busReqOut, 1);
    chk("wd_timeout_c4", timeoutOut, 0);
    step();
    chk("wd_timeout_c5", timeoutOut, 1);
    chk("wd_busreq_c5", busReqOut, 0);
    chk("wd_memvalid_c5", memValidOut, 0);
    memReqIn = 1'b0;
    step();
    chk("wd_sticky", timeoutOut, 1);
    chk("wd_idle", busReqOut, 0);

    // Reset in the middle of a MEM access
    memReqIn = 1'b1; memAddrIn = 32'h4000;
    step();
    chk("r_busreq_c1", busReqOut, 1);
    rst = 1'b1; #1;
    chk("r_stallmem_rst", stallMEMOut, 0);
    step();
    chk("r_busreq", busReqOut, 0);
    chk("r_busaddr", busAddrOut, 0);
    chk("r_timeout_clr", timeoutOut, 0);
    chk("r_memvalid", memValidOut, 0);
    rst = 1'b0; memReqIn = 1'b0; busAckIn = 1'b1; busRDataIn = 32'h55;
    step();
    chk("r_late_ack_memvalid", memValidOut, 0);
    chk("r_late_ack_busreq", busReqOut, 0);
    chk("r_late_ack_memdata", memRDataOut, 0);
    busAckIn = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory bus between the IF-stage instruction fetch and the MEM-stage load/store of the 5-stage RVX pipeline.
- Arbitrates between the two requesters and sequences each bus transaction through a req/ack handshake.
- Returns the read data to the requester and drives stall signals into the pipeline hazard control.
- Honours IF flushes from jump/branch redirects by discarding in-flight fetches.

Parameters:
BUS_W, 32, data/address width (matches `BUS_W).
TIMEOUT_CYC, 255, max cycles waiting for busAckIn before abort; 0 disables watchdog.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, synchronous, active-high.
ifReqIn  in  1  fetch request; held with ifAddrIn stable until ifValidOut.
ifAddrIn  in  BUS_W  fetch address.
ifFlushIn  in  1  discard any pending/in-flight fetch.
ifDataOut  out  BUS_W  fetched instruction.
ifValidOut  out  1  one-cycle pulse, ifDataOut valid.
memReqIn  in  1  load/store request; held stable until memValidOut.
memWeIn  in  1  1=store, 0=load.
memAddrIn  in  BUS_W  data address.
memWDataIn  in  BUS_W  store data.
memBeIn  in  4  byte enables.
memRDataOut  out  BUS_W  load data.
memValidOut  out  1  one-cycle pulse, access complete.
stallIFOut  out  1  IF must hold.
stallMEMOut  out  1  MEM (and upstream) must hold.
busReqOut  out  1  bus request, held until ack.
busWeOut  out  1  bus write enable.
busAddrOut  out  BUS_W  bus address.
busWDataOut  out  BUS_W  bus write data.
busBeOut  out  4  bus byte enables (4'hF for fetches).
busRDataIn  in  BUS_W  bus read data, valid with busAckIn.
busAckIn  in  1  transaction complete.
timeoutOut  out  1  sticky watchdog error.

Behaviour:
- Reset (sync, active-high): state IDLE. All registered outputs are 0: ifDataOut, ifValidOut, memRDataOut, memValidOut, bus*Out, timeoutOut, watchdog counter. Stall outputs are forced 0 while rst=1.
- Reset mid-transaction: state returns to IDLE, busReqOut=0 after the edge, and any later busAckIn is ignored.
- States: IDLE, IF_ACC, MEM_ACC, IF_DROP.
- IDLE arbitration, with strict MEM priority (older instruction):
  - memReqIn=1 → MEM_ACC; latch memWe/Addr/WData/Be into the bus registers.
  - else ifReqIn=1 and ifFlushIn=0 → IF_ACC; busWeOut=0, busBeOut=4'hF.
  - else stay in IDLE.
  - Bus outputs are registered, so busReqOut rises the cycle after the grant.
- IF_ACC / MEM_ACC: hold busReqOut and the other bus outputs until busAckIn=1 is sampled. On the ack edge:
  - return to IDLE and drop busReqOut.
  - capture busRDataIn into ifDataOut (IF) or into memRDataOut (MEM loads only; stores leave memRDataOut unchanged).
  - pulse the matching valid output for exactly one cycle.
- Latency: request sampled in IDLE at cycle 0 → busReqOut at cycle 1 → earliest ack at cycle 1 → valid at cycle 2. Minimum spacing between grants is 2 cycles.
- IDLE arbitrates in the same cycle a valid pulse is out. A requester whose valid is pulsing is not re-granted that cycle.
- Flush handling:
  - ifFlushIn in IF_ACC with no ack → IF_DROP.
  - IF_DROP keeps busReqOut until ack, then goes to IDLE with no ifValidOut.
  - ifFlushIn in the same cycle as the ack in IF_ACC → no ifValidOut.
  - ifFlushIn has no effect on MEM_ACC.
- Stalls (combinational):
  - stallIFOut = ifReqIn & ~ifValidOut & ~ifFlushIn.
  - stallMEMOut = memReqIn & ~memValidOut.
- Watchdog:
  - Counter increments each cycle in a non-IDLE state and clears in IDLE.
  - If the count reaches TIMEOUT_CYC without an ack: set timeoutOut (sticky until rst), drop busReqOut, go to IDLE, no valid pulse.
  - Counter width is clog2(TIMEOUT_CYC+1); it does not wrap.
- Simultaneous ifReqIn and memReqIn in IDLE: MEM is served first, then IF; IF stalls throughout.

Test Plan:
- Fetch, ack at cycle 1: ifReqIn=1, ifAddrIn=0x100, busRDataIn=0x00500093 → busAddrOut=0x100, busBeOut=F at cycle 1; ifValidOut=1, ifDataOut=0x00500093 at cycle 2; stallIFOut=1 for cycles 0–1.
- Collision: memReqIn (load 0x2000) and ifReqIn (0x104) both at cycle 0, ack 2 cycles after each request → MEM granted first, memValidOut at cycle 3 with data; IF granted at cycle 3, ifValidOut at cycle 6.
- Store: memWeIn=1, addr=0x2004, data=0xDEADBEEF, be=4'b0011 → bus outputs match; memValidOut pulses; memRDataOut unchanged.
- Flush in flight: IF_ACC with ack delayed 3 cycles, ifFlushIn pulse at cycle 2 → busReqOut held until ack; no ifValidOut; next grant proceeds normally.
- Watchdog: TIMEOUT_CYC=4, busAckIn never asserted → timeoutOut=1 after 4 waiting cycles, busReqOut=0, state IDLE, no valid.
- Reset mid-MEM_ACC: rst=1 for one cycle → all outputs 0 next cycle; a late busAckIn produces no valid pulse.
